// File: rtl/button_step_counter_pkg.sv
// Shared types and default timing for the push-button step counter.
// Holds the conditioner state encoding, the step operation codes and a counter-width helper.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLR  = 3'd1,
    OP_UP   = 3'd2,
    OP_DN   = 3'd3,
    OP_SUB  = 3'd4,
    OP_ADD  = 3'd5
  } step_op_t;

  localparam int DEF_WIDTH           = 16;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Bits needed to count 0..max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/button_step_counter_conditioner.sv
// One push-button channel: synchroniser, debouncer and press/auto-repeat pulse engine.
// The pulse is a single-cycle strobe on each press and on each repeat tick while held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic pulse
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W   = cnt_width(TM_MAX);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_HOLD   = HOLD;
  localparam logic [1:0] ST_REPEAT = REPEAT;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PER_LAST   = TM_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic                   level_r;
  logic [1:0]             state_r;
  logic [TM_W-1:0]        tmr_r;
  logic                   pulse_r;

  assign synced_s = sync_r[SYNC_STAGES-1];
  assign level    = level_r;
  assign pulse    = pulse_r;

  // Metastability synchroniser shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_r <= {SYNC_STAGES{1'b0}};
    else      sync_r <= {sync_r[SYNC_STAGES-2:0], in};
  end

  // Debounce: adopt the synced value once it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r <= {DB_W{1'b0}};
      level_r  <= 1'b0;
    end else if (synced_s != level_r) begin
      if (db_cnt_r == DB_LAST) begin
        level_r  <= synced_s;
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_r <= {DB_W{1'b0}};
    end
  end

  // Press / hold / repeat state machine producing the step pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      tmr_r   <= {TM_W{1'b0}};
      pulse_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmr_r   <= {TM_W{1'b0}};
          pulse_r <= level_r;
          if (level_r) state_r <= ST_HOLD;
          else         state_r <= ST_IDLE;
        end
        ST_HOLD: begin
          if (!level_r) begin
            state_r <= ST_IDLE;
            tmr_r   <= {TM_W{1'b0}};
            pulse_r <= 1'b0;
          end else if ((REPEAT_EN != 0) && (tmr_r == DELAY_LAST)) begin
            state_r <= ST_REPEAT;
            tmr_r   <= {TM_W{1'b0}};
            pulse_r <= 1'b1;
          end else begin
            // Without auto-repeat the timer stays parked so it can never wrap.
            tmr_r   <= (REPEAT_EN != 0) ? tmr_r + TM_W'(1) : {TM_W{1'b0}};
            pulse_r <= 1'b0;
          end
        end
        ST_REPEAT: begin
          if (!level_r) begin
            state_r <= ST_IDLE;
            tmr_r   <= {TM_W{1'b0}};
            pulse_r <= 1'b0;
          end else if (tmr_r == PER_LAST) begin
            tmr_r   <= {TM_W{1'b0}};
            pulse_r <= 1'b1;
          end else begin
            tmr_r   <= tmr_r + TM_W'(1);
            pulse_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tmr_r   <= {TM_W{1'b0}};
          pulse_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_step_counter.sv
// Up/down/step counter driven by five conditioned push-buttons, with wrap or saturate
// arithmetic and a sticky overflow flag.
module button_step_counter
  import button_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btnc,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btnl,
  input  logic             btnr,
  input  logic [WIDTH-1:0] sw,
  input  logic             mode_sat,
  output logic [WIDTH-1:0] led,
  output logic             ovf,
  output logic             step
);

  logic [4:0]       raw_s;
  logic [4:0]       pulse_s;
  logic [4:0]       unused_level_s;
  step_op_t         op_s;
  logic [WIDTH:0]   operand_s;
  logic             add_s;
  logic [WIDTH:0]   sum_s;
  logic             out_of_range_s;
  logic [WIDTH-1:0] next_led_s;
  logic [WIDTH-1:0] led_r;
  logic             ovf_r;
  logic             step_r;

  // Index order matches priority: clear, up, down, left, right.
  assign raw_s = {btnr, btnl, btnd, btnu, btnc};

  button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (0),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_cond_clr (
    .clk  (clk),
    .rst  (rst),
    .in   (raw_s[0]),
    .level(unused_level_s[0]),
    .pulse(pulse_s[0])
  );

  for (genvar i = 1; i < 5; i++) begin : g_dir
    button_conditioner #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .in   (raw_s[i]),
      .level(unused_level_s[i]),
      .pulse(pulse_s[i])
    );
  end

  // Priority encoder: coincident lower-priority pulses are dropped.
  always_comb begin
    op_s = OP_NONE;
    if      (pulse_s[0]) op_s = OP_CLR;
    else if (pulse_s[1]) op_s = OP_UP;
    else if (pulse_s[2]) op_s = OP_DN;
    else if (pulse_s[3]) op_s = OP_SUB;
    else if (pulse_s[4]) op_s = OP_ADD;
    else                 op_s = OP_NONE;
  end

  // WIDTH+1 bit add/subtract; the extra bit flags carry-out or borrow.
  always_comb begin
    operand_s = {(WIDTH + 1){1'b0}};
    add_s     = 1'b1;
    case (op_s)
      OP_UP:   begin operand_s = (WIDTH + 1)'(1); add_s = 1'b1; end
      OP_DN:   begin operand_s = (WIDTH + 1)'(1); add_s = 1'b0; end
      OP_SUB:  begin operand_s = {1'b0, sw};      add_s = 1'b0; end
      OP_ADD:  begin operand_s = {1'b0, sw};      add_s = 1'b1; end
      default: begin operand_s = {(WIDTH + 1){1'b0}}; add_s = 1'b1; end
    endcase
    if (add_s) sum_s = {1'b0, led_r} + operand_s;
    else       sum_s = {1'b0, led_r} - operand_s;
    out_of_range_s = sum_s[WIDTH];
    if (!out_of_range_s) next_led_s = sum_s[WIDTH-1:0];
    else if (mode_sat)   next_led_s = add_s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    else                 next_led_s = sum_s[WIDTH-1:0];
  end

  // Count, sticky overflow and step strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_r  <= {WIDTH{1'b0}};
      ovf_r  <= 1'b0;
      step_r <= 1'b0;
    end else begin
      case (op_s)
        OP_CLR: begin
          led_r  <= {WIDTH{1'b0}};
          ovf_r  <= 1'b0;
          step_r <= 1'b0;
        end
        OP_NONE: begin
          step_r <= 1'b0;
        end
        default: begin
          led_r  <= next_led_s;
          ovf_r  <= ovf_r | out_of_range_s;
          step_r <= 1'b1;
        end
      endcase
    end
  end

  assign led  = led_r;
  assign ovf  = ovf_r;
  assign step = step_r;

endmodule
